// File: rtl/epc_exception_controller.sv
// Interrupt entry/return sequencer around the EPC register: masks and
// arbitrates level requests, saves the resume PC, vectors to the handler, and returns on ERET.
module epc_exception_controller #(
    parameter int                    NR_IRQ        = 4,
    parameter int                    PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0]   VECTOR_BASE   = 'h0000_0800,
    parameter logic [PC_WIDTH-1:0]   VECTOR_STRIDE = 'h0000_0010
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic [NR_IRQ-1:0]    irq_req,
    input  logic                 mask_wr,
    input  logic [NR_IRQ-1:0]    mask_din,
    input  logic                 eret,
    input  logic [PC_WIDTH-1:0]  cur_pc,
    input  logic [PC_WIDTH-1:0]  epc_q,
    output logic                 epc_we,
    output logic [PC_WIDTH-1:0]  epc_d,
    output logic                 pc_redirect,
    output logic [PC_WIDTH-1:0]  pc_target,
    output logic [NR_IRQ-1:0]    irq_ack,
    output logic [NR_IRQ-1:0]    in_service,
    output logic [NR_IRQ-1:0]    irq_mask,
    output logic                 busy
);

    // state   | meaning
    // IDLE    | waiting for an unmasked request
    // SAVE    | write cur_pc into EPC
    // JUMP    | redirect to handler vector, acknowledge source
    // SERVICE | handler running, wait for ERET
    // RETURN  | redirect to EPC, end service
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        JUMP    = 3'd2,
        SERVICE = 3'd3,
        RETURN  = 3'd4
    } state_t;

    localparam int IDW = (NR_IRQ > 1) ? $clog2(NR_IRQ) : 1;

    state_t             state, state_nxt;
    logic [IDW-1:0]     id, winner;
    logic [NR_IRQ-1:0]  pending;
    logic [NR_IRQ-1:0]  id_onehot;

    assign pending = irq_req & ~irq_mask;

    // Downward scan so the lowest-index pending line wins.
    always_comb begin
        winner = '0;
        for (int i = NR_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) winner = IDW'(i);
        end
    end

    always_comb begin
        id_onehot = '0;
        id_onehot[id] = 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            id         <= '0;
            irq_mask   <= '1;
            in_service <= '0;
        end else if (Tick) begin
            state <= state_nxt;
            if (mask_wr) irq_mask <= mask_din;
            if (state == IDLE && pending != '0) id <= winner;
            if (state == JUMP) in_service <= id_onehot;
            else if (state == RETURN) in_service <= '0;
        end
    end

    always_comb begin
        state_nxt   = state;
        epc_we      = 1'b0;
        epc_d       = '0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        irq_ack     = '0;
        case (state)
            IDLE: begin
                if (pending != '0) state_nxt = SAVE;
            end
            SAVE: begin
                epc_we    = Tick;
                epc_d     = cur_pc;
                state_nxt = JUMP;
            end
            JUMP: begin
                pc_redirect = Tick;
                pc_target   = VECTOR_BASE + PC_WIDTH'(id) * VECTOR_STRIDE;
                irq_ack     = Tick ? id_onehot : '0;
                state_nxt   = SERVICE;
            end
            SERVICE: begin
                if (eret) state_nxt = RETURN;
            end
            RETURN: begin
                pc_redirect = Tick;
                pc_target   = epc_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_epc_exception_controller.sv
// Directed bench for epc_exception_controller: entry, priority, return,
// Tick stalls and asynchronous reset, checked against hand-computed values.
module tb_epc_exception_controller;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Tick;
    logic [3:0]  irq_req;
    logic        mask_wr;
    logic [3:0]  mask_din;
    logic        eret;
    logic [31:0] cur_pc;
    logic [31:0] epc_q;
    logic        epc_we;
    logic [31:0] epc_d;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [3:0]  irq_ack;
    logic [3:0]  in_service;
    logic [3:0]  irq_mask;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    epc_exception_controller dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .irq_req(irq_req),
        .mask_wr(mask_wr), .mask_din(mask_din), .eret(eret), .cur_pc(cur_pc),
        .epc_q(epc_q), .epc_we(epc_we), .epc_d(epc_d), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .irq_ack(irq_ack), .in_service(in_service),
        .irq_mask(irq_mask), .busy(busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Land 1 ns after the rising edge; inputs are then changed and
    // outputs are checked a further 1 ns later.
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Tick = 1'b1; irq_req = '0; mask_wr = 1'b0; mask_din = '0;
        eret = 1'b0; cur_pc = '0; epc_q = '0;
        cyc(); #1;
        chk("rst_mask", 32'(irq_mask), 32'hF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_epc_we", 32'(epc_we), 0);
        chk("rst_redirect", 32'(pc_redirect), 0);
        chk("rst_target", pc_target, 0);
        chk("rst_epc_d", epc_d, 0);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_ack", 32'(irq_ack), 0);

        // 1: unmask, request irq 2
        Reset = 1'b0;
        mask_wr = 1'b1; mask_din = 4'b0000; irq_req = 4'b0100; cur_pc = 32'h100;
        cyc(); mask_wr = 1'b0; #1;
        chk("t1_mask", 32'(irq_mask), 0);
        chk("t1_mask_same_tick_busy", 32'(busy), 0);
        cyc(); #1;
        chk("t1_save_we", 32'(epc_we), 1);
        chk("t1_save_d", epc_d, 32'h100);
        chk("t1_save_busy", 32'(busy), 1);
        cyc(); #1;
        chk("t1_jump_redir", 32'(pc_redirect), 1);
        chk("t1_jump_target", pc_target, 32'h820);
        chk("t1_jump_ack", 32'(irq_ack), 32'h4);
        chk("t1_jump_we", 32'(epc_we), 0);
        cyc(); irq_req = 4'b0000; eret = 1'b1; epc_q = 32'h104; #1;
        chk("t1_svc_insvc", 32'(in_service), 32'h4);
        chk("t1_svc_redir", 32'(pc_redirect), 0);
        chk("t1_svc_ack", 32'(irq_ack), 0);
        cyc(); eret = 1'b0; #1;
        chk("t1_ret_redir", 32'(pc_redirect), 1);
        chk("t1_ret_target", pc_target, 32'h104);
        cyc(); #1;
        chk("t1_idle_insvc", 32'(in_service), 0);
        chk("t1_idle_busy", 32'(busy), 0);

        // 2: simultaneous irq 1 and 3, priority to 1
        irq_req = 4'b1010;
        cyc(); cyc(); #1;
        chk("t2_jump_target", pc_target, 32'h810);
        chk("t2_jump_ack", 32'(irq_ack), 32'h2);
        cyc(); irq_req = 4'b1000; eret = 1'b1; #1;
        chk("t2_svc_insvc", 32'(in_service), 32'h2);
        cyc(); eret = 1'b0; #1;
        chk("t2_ret_redir", 32'(pc_redirect), 1);
        cyc(); #1;
        chk("t2_idle_busy", 32'(busy), 0);
        cyc(); #1;
        chk("t2_save3_we", 32'(epc_we), 1);
        cyc(); #1;
        chk("t2_jump3_target", pc_target, 32'h830);
        chk("t2_jump3_ack", 32'(irq_ack), 32'h8);

        // 3: irq 0 raised during service, then ERET
        cyc(); irq_req = 4'b0001; cur_pc = 32'h200; #1;
        chk("t3_svc_insvc", 32'(in_service), 32'h8);
        chk("t3_svc_we", 32'(epc_we), 0);
        cyc(); #1;
        chk("t3_svc_hold_busy", 32'(busy), 1);
        chk("t3_svc_hold_we", 32'(epc_we), 0);
        eret = 1'b1; epc_q = 32'h104;
        cyc(); eret = 1'b0; #1;
        chk("t3_ret_redir", 32'(pc_redirect), 1);
        chk("t3_ret_target", pc_target, 32'h104);
        chk("t3_ret_we", 32'(epc_we), 0);
        cyc(); #1;
        chk("t3_idle_busy", 32'(busy), 0);
        cyc(); #1;
        chk("t3_save0_we", 32'(epc_we), 1);
        chk("t3_save0_d", epc_d, 32'h200);

        // 4: Tick stall in SAVE
        Tick = 1'b0; #1;
        chk("t4_stall_we0", 32'(epc_we), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("t4_stall_we", 32'(epc_we), 0);
            chk("t4_stall_busy", 32'(busy), 1);
        end
        Tick = 1'b1; #1;
        chk("t4_resume_we", 32'(epc_we), 1);
        cyc(); #1;
        chk("t4_jump_we", 32'(epc_we), 0);
        chk("t4_jump_target", pc_target, 32'h800);
        chk("t4_jump_ack", 32'(irq_ack), 32'h1);
        cyc(); irq_req = 4'b0000; eret = 1'b1; epc_q = 32'h300; #1;
        cyc(); eret = 1'b0; #1;
        chk("t4_ret_target", pc_target, 32'h300);
        cyc(); eret = 1'b1; #1;
        chk("t4_idle_eret_redir", 32'(pc_redirect), 0);
        cyc(); eret = 1'b0; #1;
        chk("t4_idle_eret_busy", 32'(busy), 0);
        chk("t4_idle_eret_redir2", 32'(pc_redirect), 0);

        // 5: Reset while in JUMP
        irq_req = 4'b0100;
        cyc(); cyc(); #1;
        chk("t5_jump_redir", 32'(pc_redirect), 1);
        Reset = 1'b1; #1;
        chk("t5_rst_redir", 32'(pc_redirect), 0);
        chk("t5_rst_ack", 32'(irq_ack), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_mask", 32'(irq_mask), 32'hF);
        cyc(); Reset = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("t5_masked_busy", 32'(busy), 0);
        end
        mask_wr = 1'b1; mask_din = 4'b0000;
        cyc(); mask_wr = 1'b0; #1;
        chk("t5_unmask_busy", 32'(busy), 0);
        cyc(); #1;
        chk("t5_unmask_save", 32'(epc_we), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
